// File: rtl/iwr_pkg.sv
// Shared constants, FIFO operation encoding and word-format helpers for the
// instruction write register queue.
package iwr_pkg;

    localparam int IWR_A_BITS = 16;
    localparam int IWR_M_BITS = 32;
    localparam int IWR_DEPTH  = 4;

    // Widest word the helpers handle; the packed word is zero-padded up to this.
    localparam int IWR_MAX_W  = 128;

    typedef logic [IWR_MAX_W-1:0] iwr_word_t;

    // Per-cycle FIFO activity, encoded as {push, pop}.
    typedef enum logic [1:0] {
        FIFO_HOLD = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Odd parity: the returned bit makes the XOR over word plus parity equal 1.
    // Zero padding above the real word does not change the result.
    function automatic logic iwr_odd_parity(input iwr_word_t word);
        return ~(^word);
    endfunction

    // Places m[m_bits-1:0] in the low field and a[a_bits-1:0] directly above it.
    function automatic iwr_word_t iwr_pack(input logic [31:0] a,
                                           input logic [31:0] m,
                                           input int          a_bits,
                                           input int          m_bits);
        iwr_word_t  res;
        logic [6:0] idx;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < m_bits) begin
                idx      = 7'(i);
                res[idx] = m[5'(i)];
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (i < a_bits) begin
                idx      = 7'(m_bits + i);
                res[idx] = a[5'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iwr_fifo.sv
// Generic synchronous FIFO: storage array, wrapping pointers, occupancy count
// and full flag. The head is read straight from registered storage, so there
// is no fall-through and no combinational path from pop to any output.
module iwr_fifo
    import iwr_pkg::*;
#(
    parameter  int WIDTH = 49,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    fifo_op_e         op_s;

    // Decode this cycle's push/pop pair into one operation.
    always_comb begin
        op_s = fifo_op_e'({push, pop});
    end

    // Storage, pointers and occupancy; flush empties the queue but keeps storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            case (op_s)
                FIFO_PUSH: begin
                    mem_r[wr_ptr_r] <= push_data;
                    wr_ptr_r        <= wr_ptr_r + PW'(1);
                    count_r         <= count_r + CW'(1);
                end
                FIFO_POP: begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                    count_r  <= count_r - CW'(1);
                end
                FIFO_BOTH: begin
                    // When full, wr_ptr equals rd_ptr: the slot being vacated
                    // by the pop receives the new tail, preserving order.
                    mem_r[wr_ptr_r] <= push_data;
                    wr_ptr_r        <= wr_ptr_r + PW'(1);
                    rd_ptr_r        <= rd_ptr_r + PW'(1);
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head_data  = mem_r[rd_ptr_r];
    assign head_valid = (count_r != '0);
    assign count      = count_r;
    assign full       = (count_r == CW'(DEPTH));

endmodule

// File: rtl/iwr_queue.sv
// Instruction write register with posted-write queue. A write request during
// state_fetch captures {parity, a[A_BITS-1:0], m[M_BITS-1:0]} into the legacy
// holding register iwr and posts the same word to a FIFO drained over a
// valid/ready port. Optional feature macro: IWR_PARITY_EN (odd parity in the
// top bit; when undefined the top bit is constant 0).
module iwr_queue
    import iwr_pkg::*;
#(
    parameter  int A_BITS = IWR_A_BITS,
    parameter  int M_BITS = IWR_M_BITS,
    parameter  int DEPTH  = IWR_DEPTH,
    localparam int W      = A_BITS + M_BITS + 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          state_fetch,
    input  logic          wr_req,
    input  logic [31:0]   a,
    input  logic [31:0]   m,
    input  logic          flush,
    output logic [W-1:0]  iwr,
    output logic          wr_valid,
    output logic [W-1:0]  wr_data,
    input  logic          wr_ready,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow
);

    logic                 capture_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 drop_s;
    logic [W-2:0]         body_s;
    logic [IWR_MAX_W-W:0] pack_unused_s;
    logic [W-1:0]         word_s;
    logic [W-1:0]         iwr_r;
    logic                 overflow_r;
    logic                 fifo_valid_s;
    logic                 fifo_full_s;

    // Format the captured word; parity covers every data bit below it.
    always_comb begin
        {pack_unused_s, body_s} = iwr_pack(a, m, A_BITS, M_BITS);
`ifdef IWR_PARITY_EN
        word_s = {iwr_odd_parity(iwr_word_t'(body_s)), body_s};
`else
        word_s = {1'b0, body_s};
`endif
    end

    // Qualify capture and derive push/pop; flush overrides both.
    always_comb begin
        capture_s = state_fetch & wr_req;
        pop_s     = fifo_valid_s & wr_ready & ~flush;
        push_s    = capture_s & ~flush & (~fifo_full_s | pop_s);
        drop_s    = capture_s & ~flush & fifo_full_s & ~pop_s;
    end

    // Holding register loads on every capture, even when the FIFO drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            iwr_r <= '0;
        end else if (capture_s) begin
            iwr_r <= word_s;
        end else begin
            iwr_r <= iwr_r;
        end
    end

    // Sticky record of a capture lost to a full queue; only flush/reset clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    iwr_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push_s),
        .pop        (pop_s),
        .push_data  (word_s),
        .head_valid (fifo_valid_s),
        .head_data  (wr_data),
        .count      (count),
        .full       (fifo_full_s)
    );

    assign iwr      = iwr_r;
    assign wr_valid = fifo_valid_s;
    assign full     = fifo_full_s;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_iwr_queue.sv
// Directed self-checking bench for iwr_queue with default parameters
// (A_BITS=16, M_BITS=32, DEPTH=4, W=49).
module tb_iwr_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        state_fetch;
    logic        wr_req;
    logic [31:0] a;
    logic [31:0] m;
    logic        flush;
    logic [48:0] iwr;
    logic        wr_valid;
    logic [48:0] wr_data;
    logic        wr_ready;
    logic [2:0]  count;
    logic        full;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    iwr_queue dut (
        .clk         (clk),
        .reset       (reset),
        .state_fetch (state_fetch),
        .wr_req      (wr_req),
        .a           (a),
        .m           (m),
        .flush       (flush),
        .iwr         (iwr),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .count       (count),
        .full        (full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] exp_word(input logic [31:0] av, input logic [31:0] mv);
        logic [47:0] b;
        b = {av[15:0], mv};
`ifdef IWR_PARITY_EN
        return {~(^b), b};
`else
        return {1'b0, b};
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] av, input logic [31:0] mv);
        state_fetch = 1'b1;
        wr_req      = 1'b1;
        a           = av;
        m           = mv;
        cycle();
        state_fetch = 1'b0;
        wr_req      = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_iwr"},      64'(iwr),      64'(0));
        check({tag, "_valid"},    64'(wr_valid), 64'(0));
        check({tag, "_data"},     64'(wr_data),  64'(0));
        check({tag, "_count"},    64'(count),    64'(0));
        check({tag, "_full"},     64'(full),     64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    task automatic single_write(input string tag);
        wr_ready = 1'b0;
        capture(32'h0000_1234, 32'hDEAD_BEEF);
        check({tag, "_iwr"},   64'(iwr),      64'(exp_word(32'h0000_1234, 32'hDEAD_BEEF)));
        check({tag, "_data"},  64'(wr_data),  64'(exp_word(32'h0000_1234, 32'hDEAD_BEEF)));
        check({tag, "_valid"}, 64'(wr_valid), 64'(1));
        check({tag, "_count"}, 64'(count),    64'(1));
`ifdef IWR_PARITY_EN
        check({tag, "_par"},   64'(iwr[48]),  64'(0));
`else
        check({tag, "_word"},  64'(iwr),      64'(49'h0_1234_DEAD_BEEF));
`endif
    endtask

    logic [48:0] q [$];
    logic [48:0] prev_data;
    logic        prev_stall;
    logic        ovf_m;
    logic        cap;
    logic        pop_m;
    logic        full_m;
    logic [31:0] av;
    logic [31:0] mv;
    int          caps;
    int          guard;

    initial begin
        reset = 1'b1; state_fetch = 1'b0; wr_req = 1'b0; a = '0; m = '0;
        flush = 1'b0; wr_ready = 1'b0;
        cycle();
        cycle();
        check_reset("rst");
        reset = 1'b0;

        // Single write and non-capturing strobes
        single_write("sw");
        state_fetch = 1'b1; wr_req = 1'b0; m = 32'h1;
        cycle();
        state_fetch = 1'b0; wr_req = 1'b1;
        cycle();
        wr_req = 1'b0;
        check("no_cap_count", 64'(count), 64'(1));
        check("no_cap_iwr", 64'(iwr), 64'(exp_word(32'h0000_1234, 32'hDEAD_BEEF)));
        wr_ready = 1'b1;
        cycle();
        check("sw_drain_valid", 64'(wr_valid), 64'(0));

        // Empty queue, push with wr_ready high: no fall-through
        capture(32'h0, 32'h55);
        check("nofall_valid", 64'(wr_valid), 64'(1));
        check("nofall_count", 64'(count), 64'(1));
        cycle();
        check("nofall_popped", 64'(count), 64'(0));

        // Fill and overflow
        wr_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            capture(32'h0, 32'(k));
            if (k == 4) begin
                check("fill_full", 64'(full), 64'(1));
                check("fill_ovf0", 64'(overflow), 64'(0));
            end
        end
        check("ovf_set", 64'(overflow), 64'(1));
        check("ovf_iwr", 64'(iwr[31:0]), 64'(5));
        check("ovf_count", 64'(count), 64'(4));
        wr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("fill_drain", 64'(wr_data[31:0]), 64'(k));
            cycle();
        end
        wr_ready = 1'b0;
        check("fill_empty", 64'(count), 64'(0));
        check("ovf_sticky", 64'(overflow), 64'(1));

        // Flush priority over a simultaneous capture
        for (int k = 11; k <= 13; k++) capture(32'h0, 32'(k));
        check("fl_pre_count", 64'(count), 64'(3));
        flush = 1'b1;
        capture(32'h0, 32'd7);
        flush = 1'b0;
        check("fl_count", 64'(count), 64'(0));
        check("fl_valid", 64'(wr_valid), 64'(0));
        check("fl_ovf", 64'(overflow), 64'(0));
        check("fl_iwr", 64'(iwr[31:0]), 64'(7));

        // Simultaneous push and pop while full
        for (int k = 21; k <= 24; k++) capture(32'h0, 32'(k));
        check("pp_full", 64'(full), 64'(1));
        wr_ready = 1'b1;
        check("pp_head", 64'(wr_data[31:0]), 64'(21));
        capture(32'h0, 32'd9);
        check("pp_count", 64'(count), 64'(4));
        check("pp_ovf", 64'(overflow), 64'(0));
        check("pp_d22", 64'(wr_data[31:0]), 64'(22)); cycle();
        check("pp_d23", 64'(wr_data[31:0]), 64'(23)); cycle();
        check("pp_d24", 64'(wr_data[31:0]), 64'(24)); cycle();
        check("pp_d9",  64'(wr_data[31:0]), 64'(9));  cycle();
        check("pp_empty", 64'(count), 64'(0));

        // Random captures with random backpressure against a queue model
        ovf_m = 1'b0; prev_stall = 1'b0; prev_data = '0; caps = 0; guard = 0;
        while (caps < 20 && guard < 200) begin
            guard++;
            cap = ($urandom_range(0, 3) != 0);
            wr_ready = 1'($urandom_range(0, 1));
            av = $urandom; mv = $urandom;
            if (prev_stall) check("stall_stable", 64'(wr_data), 64'(prev_data));
            check("rnd_valid", 64'(wr_valid), 64'(q.size() != 0));
            check("rnd_count", 64'(count), 64'(q.size()));
            full_m = (q.size() == 4);
            pop_m  = (q.size() != 0) && wr_ready;
            if (pop_m) begin
                check("rnd_head", 64'(wr_data), 64'(q[0]));
                void'(q.pop_front());
            end
            if (cap) begin
                caps++;
                if (!full_m || pop_m) q.push_back(exp_word(av, mv));
                else ovf_m = 1'b1;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_data  = wr_data;
            state_fetch = cap; wr_req = cap; a = av; m = mv;
            cycle();
            state_fetch = 1'b0; wr_req = 1'b0;
        end
        check("rnd_caps", 64'(caps), 64'(20));
        wr_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            guard++;
            check("rnd_drain", 64'(wr_data), 64'(q[0]));
            void'(q.pop_front());
            cycle();
        end
        check("rnd_final_count", 64'(count), 64'(0));
        check("rnd_ovf", 64'(overflow), 64'(ovf_m));

        // Reset mid-stream
        wr_ready = 1'b0;
        capture(32'h0, 32'hA1);
        capture(32'h0, 32'hA2);
        check("mr_pre_count", 64'(count), 64'(2));
        reset = 1'b1;
        cycle();
        check_reset("mr");
        reset = 1'b0;
        single_write("mr_sw");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/iwr_queue.md
# iwr_queue

Parametrised instruction write register with a posted-write queue for the microcode control-memory write path. Each `state_fetch` cycle that carries a write request captures a control-memory word from the A and M buses. The word lands in a legacy-compatible holding register and is also pushed into a small FIFO. A valid/ready port drains the FIFO to the control-memory writer, so back-to-back microcode writes no longer stall the processor while the writer is busy.

## Interface
Parameters:
- `A_BITS`, 16: number of low bits of `a` captured as the high data field.
- `M_BITS`, 32: number of low bits of `m` captured as the low data field.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- Derived `W = A_BITS + M_BITS + 1`: word width; the top bit is parity (or 0). The default is 49.

Ports (reset reset, synchronous, active-high; clock clk):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `state_fetch`  in  1  processor fetch-state strobe.
- `wr_req`  in  1  qualifies capture; capture = `state_fetch & wr_req`.
- `a`  in  32  A bus.
- `m`  in  32  M bus.
- `flush`  in  1  discards queue contents and clears `overflow`.
- `iwr`  out  W  last captured word (holding register).
- `wr_valid`  out  1  FIFO head is valid.
- `wr_data`  out  W  FIFO head word.
- `wr_ready`  in  1  writer accepts the head when `wr_valid & wr_ready`.
- `count`  out  clog2(DEPTH+1)  occupied entries.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky flag: a capture was dropped.

## Operation
- Word format:
  - `[W-2:M_BITS]` = `a[A_BITS-1:0]`.
  - `[M_BITS-1:0]` = `m[M_BITS-1:0]`.
  - `[W-1]` = parity bit (see Configuration).
- `iwr` loads the formatted word on every capture, whether or not the FIFO accepts it. Otherwise it holds.
- Push is `capture & ~flush & (~full | pop)`. Pop is `wr_valid & wr_ready & ~flush`.
- Capture while full with no pop in the same cycle: the word is dropped from the FIFO and `overflow` sets. `iwr` still updates.
- Full with push and pop together: both happen; `count` is unchanged and FIFO order is preserved.
- Empty with push and `wr_ready` high: no fall-through. The word becomes visible the next cycle.
- `flush` wins over push and pop. Next cycle: `count`=0, `wr_valid`=0, `overflow`=0. `iwr` still loads if capture is high that cycle.
- Read and write pointers wrap modulo DEPTH. `count` is the authoritative full/empty indicator.
- `wr_data` is stable while `wr_valid & ~wr_ready`. It is don't-care when `wr_valid`=0.
- Reset mid-operation discards all entries. In-flight writer state is the writer's responsibility.

## Timing
- Reset values: `iwr`=0, `wr_valid`=0, `wr_data`=0 (storage cleared), `count`=0, `full`=0, `overflow`=0.
- Capture to `iwr`: 1 cycle.
- Capture to `wr_valid` (empty queue): 1 cycle.
- Pop to next head on `wr_data`: 1 cycle.
- Throughput: one push and one pop per cycle.
- All outputs are registered or decoded directly from registered state.
- There is no combinational path from `wr_ready` to any output.

## Configuration
- `IWR_PARITY_EN` defined: bit `W-1` holds odd parity over bits `[W-2:0]`, so the XOR of all W bits is 1. Parity is computed at capture and applies to both `iwr` and the FIFO entry.
- `IWR_PARITY_EN` undefined: bit `W-1` is constant 0. This is the legacy behaviour; the parity logic is not synthesised.

## Structure
- Package `iwr_pkg` contains:
  - default constants `IWR_A_BITS`=16, `IWR_M_BITS`=32, `IWR_DEPTH`=4;
  - function `iwr_odd_parity(word)`;
  - a word-format helper `iwr_pack(a, m)`.
- One sub-module, `iwr_fifo`. It is generic over width and depth and holds the storage array, pointers, `count` and `full`. It has no knowledge of capture or parity.
- `iwr_queue` itself holds the capture qualify logic, word packing, the `iwr` holding register and the `overflow` flag.

## Test plan
- **Reset, then single write:** reset 2 cycles, then one capture with a=32'h0000_1234, m=32'hDEAD_BEEF.
  - Next cycle: `iwr`=`wr_data`=49'h0_1234_DEAD_BEEF (parity off) and `wr_valid`=1, `count`=1.
  - With `IWR_PARITY_EN`: bit 48 = 0.
- **Fill and overflow:** `wr_ready`=0, 5 captures with m=1..5 (DEPTH 4).
  - `full`=1 after the 4th, `overflow`=1 after the 5th, `iwr[31:0]`=5.
  - Drain yields m=1,2,3,4 in order.
- **Simultaneous push/pop at full:** queue full, `wr_ready`=1 and a capture (m=9) in the same cycle.
  - `count` stays 4, `overflow` stays 0, 9 is the last word drained.
- **Flush priority:** 3 entries queued and `overflow`=1; assert `flush` together with a capture (m=7).
  - Next cycle: `count`=0, `wr_valid`=0, `overflow`=0, `iwr[31:0]`=7.
- **Wrap-around and backpressure:** 20 random captures with random `wr_ready`.
  - Drained sequence equals the accepted-capture sequence.
  - `wr_data` stays stable during every stall.
- **Reset mid-stream:** assert `reset` with 2 entries queued.
  - Next cycle: all outputs at their reset values; a subsequent capture behaves as in the single-write test.
